// File: rtl/efuse_array_ctrl.sv
// efuse_array_ctrl: sequences preset/sense reads and timed program pulses on a raw eFuse array macro
module efuse_array_ctrl #(
  parameter int NWORDS        = 64,
  parameter int WORD_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 6,
  parameter int PRESET_CYCLES = 2,
  parameter int SENSE_CYCLES  = 2,
  parameter int PROG_CYCLES   = 110
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [WORD_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [WORD_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [NWORDS-1:0]     efuse_bit_sel,
  output logic [WORD_WIDTH-1:0] efuse_col_prog_n,
  output logic                  efuse_preset_n,
  output logic                  efuse_sense,
  input  logic [WORD_WIDTH-1:0] efuse_out
);
  localparam int PSMAX = PRESET_CYCLES > SENSE_CYCLES ? PRESET_CYCLES : SENSE_CYCLES;
  localparam int MAXC  = PSMAX > PROG_CYCLES ? PSMAX : PROG_CYCLES;
  localparam int CW    = $clog2(MAXC + 1);
  typedef enum logic [2:0] {IDLE, PRESET, SENSE, PROG, DONE} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic [WORD_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [NWORDS-1:0]     bit_sel_q, bit_sel_d;
  logic [WORD_WIDTH-1:0] col_prog_n_q, col_prog_n_d;
  logic                  preset_n_q, preset_n_d;
  logic                  sense_q, sense_d;
  logic                  hs, bad;
  assign cmd_ready        = state_q == IDLE;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_rdata        = rsp_rdata_q;
  assign rsp_err          = rsp_err_q;
  assign efuse_bit_sel    = bit_sel_q;
  assign efuse_col_prog_n = col_prog_n_q;
  assign efuse_preset_n   = preset_n_q;
  assign efuse_sense      = sense_q;
  always_comb begin
    hs      = cmd_valid && state_q == IDLE;
    bad     = 32'(cmd_addr) >= NWORDS;
    addr_d  = hs ? cmd_addr : addr_q;
    wdata_d = hs ? cmd_wdata : wdata_q;
    state_d = state_q;
    cnt_d   = cnt_q - CW'(1);
    case (state_q)
      IDLE: begin
        cnt_d = cmd_write ? CW'(PROG_CYCLES - 1) : CW'(PRESET_CYCLES - 1);
        if (cmd_valid)
          state_d = bad || (cmd_write && cmd_wdata == '0) ? DONE : cmd_write ? PROG : PRESET;
      end
      PRESET: if (cnt_q == '0) begin
        state_d = SENSE;
        cnt_d   = CW'(SENSE_CYCLES - 1);
      end
      SENSE, PROG: state_d = cnt_q == '0 ? DONE : state_q;
      default: state_d = IDLE;
    endcase
    rsp_valid_d  = state_d == DONE;
    rsp_err_d    = state_d == DONE ? state_q == IDLE && bad : rsp_err_q;
    rsp_rdata_d  = state_d == DONE ? (state_q == SENSE ? efuse_out : '0) : rsp_rdata_q;
    bit_sel_d    = state_d == SENSE || state_d == PROG ? NWORDS'(1) << addr_d : '0;
    col_prog_n_d = state_d == PROG ? ~wdata_d : '1;
    preset_n_d   = state_d != PRESET;
    sense_d      = state_d == SENSE;
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      bit_sel_q    <= '0;
      col_prog_n_q <= '1;
      preset_n_q   <= 1'b1;
      sense_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      bit_sel_q    <= bit_sel_d;
      col_prog_n_q <= col_prog_n_d;
      preset_n_q   <= preset_n_d;
      sense_q      <= sense_d;
    end
  end
endmodule

// File: tb/tb_efuse_array_ctrl.sv
// tb_efuse_array_ctrl: scoreboard bench with a behavioural fuse array model and per-cycle pin invariant checks
module tb_efuse_array_ctrl;
  localparam int NW = 64, WW = 32, AW = 7, PC = 2, SC = 2, GC = 110;
  typedef struct {
    int           t;
    logic [WW-1:0] rdata;
    logic          err;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [WW-1:0] cmd_wdata = '0, efuse_out = '0;
  logic cmd_ready, rsp_valid, rsp_err, efuse_preset_n, efuse_sense;
  logic [WW-1:0] rsp_rdata, efuse_col_prog_n;
  logic [NW-1:0] efuse_bit_sel;
  int checks = 0, failures = 0, cyc = 0;
  logic [WW-1:0] fuse [NW];
  logic [WW-1:0] exp_fuse [NW];
  logic [WW-1:0] last_rdata = '0, saved, pcol = '0;
  logic [NW-1:0] psel = '0, ssel = '0;
  int plen = 0, slen = 0, rlen = 0;
  logic abort = 1'b0;
  exp_t q[$];
  always #5 clk = ~clk;
  efuse_array_ctrl #(
    .NWORDS(NW), .WORD_WIDTH(WW), .ADDR_WIDTH(AW),
    .PRESET_CYCLES(PC), .SENSE_CYCLES(SC), .PROG_CYCLES(GC)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .efuse_bit_sel(efuse_bit_sel), .efuse_col_prog_n(efuse_col_prog_n),
    .efuse_preset_n(efuse_preset_n), .efuse_sense(efuse_sense), .efuse_out(efuse_out)
  );
  function automatic int idx_of(input logic [NW-1:0] s);
    idx_of = 0;
    for (int i = 0; i < NW; i++) if (s[i]) idx_of = i;
  endfunction
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    exp_t e;
    logic idle;
    @(negedge clk);
    cyc++;
    idle = efuse_bit_sel == '0 && efuse_col_prog_n == '1 && efuse_preset_n && !efuse_sense;
    chk("pin_inv", {$onehot0(efuse_bit_sel),
                    efuse_col_prog_n == '1 || ($onehot(efuse_bit_sel) && efuse_preset_n && !efuse_sense),
                    efuse_preset_n || (efuse_bit_sel == '0 && !efuse_sense && efuse_col_prog_n == '1),
                    !efuse_sense || ($onehot(efuse_bit_sel) && efuse_preset_n),
                    !(rsp_valid || cmd_ready) || idle}, 5'b11111);
    if (rsp_valid) begin
      chk("rsp_expected", q.size() > 0, 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rsp_cycle", cyc, e.t);
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", rsp_err, e.err);
        last_rdata = e.rdata;
      end
    end else chk("rdata_hold", rsp_rdata, last_rdata);
    if (efuse_col_prog_n != '1) begin
      if (plen > 0) chk("prog_stable", {efuse_bit_sel, efuse_col_prog_n}, {psel, pcol});
      plen++;
      psel = efuse_bit_sel;
      pcol = efuse_col_prog_n;
    end else if (plen > 0) begin
      if (!abort) chk("prog_len", plen, GC);
      if (plen >= GC && $onehot(psel)) fuse[idx_of(psel)] |= ~pcol;
      plen = 0;
    end
    if (efuse_sense) begin
      if (slen > 0) chk("sense_sel_stable", efuse_bit_sel, ssel);
      slen++;
      ssel = efuse_bit_sel;
    end else if (slen > 0) begin
      if (!abort) chk("sense_len", slen, SC);
      slen = 0;
    end
    if (!efuse_preset_n) rlen++;
    else if (rlen > 0) begin
      if (!abort) chk("preset_len", rlen, PC);
      rlen = 0;
    end
    efuse_out = efuse_sense && $onehot(efuse_bit_sel) ? fuse[idx_of(efuse_bit_sel)] : 32'hBAD0_BAD0;
  endtask
  task automatic send(input logic w, input int a, input logic [WW-1:0] d);
    exp_t e;
    logic bad;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = AW'(a);
    cmd_wdata = d;
    for (int i = 0; i < 300 && !cmd_ready; i++) tick();
    chk("ready_wait", cmd_ready, 1);
    bad     = a >= NW;
    e.t     = cyc + ((bad || (w && d == '0)) ? 1 : w ? GC + 1 : PC + SC + 1);
    e.err   = bad;
    e.rdata = (!bad && !w) ? exp_fuse[a] : '0;
    if (!bad && w) exp_fuse[a] |= d;
    q.push_back(e);
    tick();
  endtask
  task automatic drain();
    for (int i = 0; i < 300 && q.size() > 0; i++) tick();
    chk("drain", q.size(), 0);
  endtask
  task automatic idle_for(input string tag, input int n);
    for (int k = 1; k <= n; k++) begin
      if (k > 1) tick();
      chk(tag, {efuse_preset_n, efuse_sense, efuse_bit_sel, efuse_col_prog_n}, {1'b1, 1'b0, 64'h0, 32'hFFFF_FFFF});
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    logic w;
    int a;
    logic [WW-1:0] d;
    for (int i = 0; i < NW; i++) begin
      fuse[i] = '0;
      exp_fuse[i] = '0;
    end
    fuse[5] = 32'hDEAD_BEEF;
    exp_fuse[5] = 32'hDEAD_BEEF;
    repeat (3) tick();
    chk("reset_ctl", {cmd_ready, rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 1'b0, 32'h0});
    chk("reset_pins", {efuse_preset_n, efuse_sense, efuse_bit_sel, efuse_col_prog_n}, {1'b1, 1'b0, 64'h0, 32'hFFFF_FFFF});
    rst = 1'b0;
    tick();
    send(1'b0, 5, '0);
    cmd_valid = 1'b0;
    cmd_write = 1'b1;
    cmd_addr  = 7'h11;
    cmd_wdata = '1;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) tick();
      chk($sformatf("read_seq k=%0d", k), {efuse_preset_n, efuse_sense, cmd_ready, efuse_bit_sel},
          {!(k <= 2), k == 3 || k == 4, k == 6, (k == 3 || k == 4) ? 64'h20 : 64'h0});
    end
    send(1'b1, 63, 32'h81);
    cmd_valid = 1'b0;
    cmd_wdata = '0;
    for (int k = 1; k <= 112; k++) begin
      if (k > 1) tick();
      chk($sformatf("prog_seq k=%0d", k), {efuse_bit_sel, efuse_col_prog_n},
          k <= GC ? {64'h8000_0000_0000_0000, 32'hFFFF_FF7E} : {64'h0, 32'hFFFF_FFFF});
    end
    send(1'b0, 63, '0);
    cmd_valid = 1'b0;
    drain();
    send(1'b1, 10, '0);
    cmd_valid = 1'b0;
    idle_for("zero_write_idle", 2);
    drain();
    send(1'b1, 64, 32'h0000_FFFF);
    cmd_valid = 1'b0;
    idle_for("bad_addr_idle", 2);
    drain();
    saved = exp_fuse[3];
    send(1'b1, 3, 32'hF0);
    cmd_valid = 1'b0;
    repeat (49) tick();
    chk("prog_before_reset", efuse_col_prog_n, 32'hFFFF_FF0F);
    rst = 1'b1;
    abort = 1'b1;
    q.delete();
    exp_fuse[3] = saved;
    last_rdata = '0;
    tick();
    chk("reset_mid_prog", {cmd_ready, rsp_valid, efuse_preset_n, efuse_sense, efuse_bit_sel, efuse_col_prog_n},
        {1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 32'hFFFF_FFFF});
    rst = 1'b0;
    tick();
    abort = 1'b0;
    send(1'b0, 3, '0);
    send(1'b1, 3, 32'h0F00_000F);
    send(1'b0, 3, '0);
    cmd_valid = 1'b0;
    drain();
    for (int n = 0; n < 40; n++) begin
      w = $urandom_range(0, 3) == 0;
      a = $urandom_range(0, 69);
      d = $urandom_range(0, 7) == 0 ? '0 : $urandom;
      send(w, a, d);
    end
    cmd_valid = 1'b0;
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
